// File: rtl/fsm_pattern_gen.sv
// rtl/fsm_pattern_gen.sv - run-length segment player driving the serial X input
module fsm_pattern_gen #(
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned DEPTH      = 4,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     seg_valid,
  output logic                     seg_ready,
  input  logic                     seg_level,
  input  logic [LEN_W-1:0]         seg_len,
  output logic                     X,
  output logic                     x_active,
  output logic                     seg_done,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = LEN_W + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // FIFO storage: each entry is {level, length}
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  state_e           state_q;
  state_e           state_d;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_d;
  logic             x_q;
  logic             x_d;
  logic             active_q;
  logic             active_d;

  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             head_level;
  logic [LEN_W-1:0] head_len;

  // Ready depends only on the registered count; a same-cycle pop never frees a slot early.
  assign seg_ready  = (count_q != CNT_W'(DEPTH));
  assign fifo_empty = (count_q == '0);
  // Zero-length segments complete the handshake but are never stored.
  assign push       = seg_valid && seg_ready && (seg_len != '0);
  assign {head_level, head_len} = mem_q[rd_ptr_q];

  assign X          = x_q;
  assign x_active   = active_q;
  assign seg_done   = (state_q == ST_RUN) && (cnt_q == '0);
  assign fifo_count = count_q;

  // Segment storage write port; contents are don't-care until pointed at by a valid count.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {seg_level, seg_len};
    end
  end

  // Occupancy tracking: push and pop in the same cycle cancel out.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and count, wrapping naturally at the power-of-two depth.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Player next-state: load a new segment whenever the current one ends and one is waiting.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    active_d = active_q;
    pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          x_d      = head_level;
          cnt_d    = head_len - LEN_W'(1);
          active_d = 1'b1;
          state_d  = ST_RUN;
        end else begin
          x_d      = IDLE_LEVEL;
        end
      end
      ST_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LEN_W'(1);
        end else if (!fifo_empty) begin
          pop   = 1'b1;
          x_d   = head_level;
          cnt_d = head_len - LEN_W'(1);
        end else begin
          x_d      = IDLE_LEVEL;
          active_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        x_d      = IDLE_LEVEL;
        active_d = 1'b0;
      end
    endcase
  end

  // Player state register; reset forces the idle level onto X immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      x_q      <= IDLE_LEVEL;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      active_q <= active_d;
    end
  end

endmodule

// File: tb/tb_fsm_pattern_gen.sv
// tb/tb_fsm_pattern_gen.sv - scoreboard bench for fsm_pattern_gen
module tb_fsm_pattern_gen;

  logic       clock;
  logic       reset;
  logic       seg_valid;
  logic       seg_ready;
  logic       seg_level;
  logic [7:0] seg_len;
  logic       X;
  logic       x_active;
  logic       seg_done;
  logic [2:0] fifo_count;

  typedef struct packed {
    logic level;
    logic done;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int checks    = 0;
  int failures  = 0;
  int act_len   = 0;
  int last_run  = 0;
  int done_cnt  = 0;
  bit full_seen = 0;
  bit mon_en    = 0;

  fsm_pattern_gen #(
    .LEN_W(8),
    .DEPTH(4),
    .IDLE_LEVEL(1'b0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .seg_valid(seg_valid),
    .seg_ready(seg_ready),
    .seg_level(seg_level),
    .seg_len(seg_len),
    .X(X),
    .x_active(x_active),
    .seg_done(seg_done),
    .fifo_count(fifo_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output monitor: every active cycle must match the next scoreboard entry.
  always @(negedge clock) begin
    if (mon_en) begin
      checks++;
      if (seg_ready !== (fifo_count != 3'd4)) begin
        failures++;
        $display("FAIL ready_flag seg_ready=%b fifo_count=%0d", seg_ready, fifo_count);
      end
      if (fifo_count == 3'd4) full_seen = 1;
      if (x_active === 1'b1) begin
        act_len++;
        if (seg_done === 1'b1) done_cnt++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_active X=%b seg_done=%b expected idle", X, seg_done);
        end else begin
          mon_e = sb.pop_front();
          if (X !== mon_e.level || seg_done !== mon_e.done) begin
            failures++;
            $display("FAIL stream X=%b seg_done=%b expected X=%b seg_done=%b",
                     X, seg_done, mon_e.level, mon_e.done);
          end
        end
      end else begin
        if (act_len != 0) begin
          last_run = act_len;
          act_len  = 0;
        end
        checks++;
        if (X !== 1'b0 || seg_done !== 1'b0) begin
          failures++;
          $display("FAIL idle_out X=%b seg_done=%b expected 0 0", X, seg_done);
        end
      end
    end
  end

  task automatic push_seg(input logic lvl, input logic [7:0] len);
    logic ok;
    bit   acc;
    acc = 0;
    @(negedge clock);
    seg_valid = 1'b1;
    seg_level = lvl;
    seg_len   = len;
    for (int t = 0; t < 1000 && !acc; t++) begin
      ok = seg_ready;
      @(posedge clock);
      if (ok) begin
        acc = 1;
        for (int i = 0; i < int'(len); i++) sb.push_back('{lvl, (i == int'(len) - 1)});
      end else begin
        @(negedge clock);
      end
    end
    #1 seg_valid = 1'b0;
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL push_timeout level=%b len=%0d not accepted", lvl, len);
    end
  endtask

  task automatic drain(input int budget);
    bit ok;
    ok = 0;
    for (int t = 0; t < budget && !ok; t++) begin
      @(negedge clock);
      #1;
      if (sb.size() == 0 && x_active === 1'b0) ok = 1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d x_active=%b", sb.size(), x_active);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    seg_valid = 1'b0;
    seg_level = 1'b0;
    seg_len   = 8'd0;
    #12;
    checks++;
    if (X !== 1'b0 || x_active !== 1'b0 || seg_done !== 1'b0 || fifo_count !== 3'd0 || seg_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state X=%b act=%b done=%b cnt=%0d rdy=%b expected 0 0 0 0 1",
               X, x_active, seg_done, fifo_count, seg_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    #1 mon_en = 1;
  endtask

  task automatic test_single();
    push_seg(1'b1, 8'd1);
    @(negedge clock);
    checks++;
    if (fifo_count !== 3'd1 || X !== 1'b0) begin
      failures++;
      $display("FAIL single_queued cnt=%0d X=%b expected 1 0", fifo_count, X);
    end
    @(negedge clock);
    checks++;
    if (X !== 1'b1 || seg_done !== 1'b1 || fifo_count !== 3'd0 || x_active !== 1'b1) begin
      failures++;
      $display("FAIL single_run X=%b done=%b cnt=%0d act=%b expected 1 1 0 1",
               X, seg_done, fifo_count, x_active);
    end
    @(negedge clock);
    #1;
    checks++;
    if (X !== 1'b0 || x_active !== 1'b0 || last_run != 1) begin
      failures++;
      $display("FAIL single_end X=%b act=%b run=%0d expected 0 0 1", X, x_active, last_run);
    end
  endtask

  task automatic test_reference();
    done_cnt = 0;
    push_seg(1'b0, 8'd3);
    push_seg(1'b1, 8'd4);
    push_seg(1'b0, 8'd7);
    push_seg(1'b1, 8'd10);
    push_seg(1'b0, 8'd4);
    drain(200);
    checks++;
    if (last_run != 28 || done_cnt != 5) begin
      failures++;
      $display("FAIL reference_run run=%0d done=%0d expected 28 5", last_run, done_cnt);
    end
  endtask

  task automatic test_full();
    full_seen = 0;
    done_cnt  = 0;
    for (int k = 0; k < 6; k++) push_seg(logic'(k % 2 == 0), 8'd5);
    drain(200);
    checks++;
    if (!full_seen || last_run != 30 || done_cnt != 6) begin
      failures++;
      $display("FAIL full_fifo full_seen=%0b run=%0d done=%0d expected 1 30 6",
               full_seen, last_run, done_cnt);
    end
  endtask

  task automatic test_zero_len();
    done_cnt = 0;
    push_seg(1'b0, 8'd2);
    push_seg(1'b1, 8'd0);
    push_seg(1'b0, 8'd2);
    drain(50);
    checks++;
    if (last_run != 4 || done_cnt != 2) begin
      failures++;
      $display("FAIL zero_len run=%0d done=%0d expected 4 2", last_run, done_cnt);
    end
  endtask

  task automatic test_max_len();
    done_cnt = 0;
    push_seg(1'b1, 8'd255);
    drain(400);
    checks++;
    if (last_run != 255 || done_cnt != 1) begin
      failures++;
      $display("FAIL max_len run=%0d done=%0d expected 255 1", last_run, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    push_seg(1'b1, 8'd10);
    push_seg(1'b0, 8'd4);
    push_seg(1'b1, 8'd5);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (fifo_count !== 3'd2 || x_active !== 1'b1 || X !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset cnt=%0d act=%b X=%b expected 2 1 1", fifo_count, x_active, X);
    end
    mon_en = 0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (X !== 1'b0 || fifo_count !== 3'd0 || x_active !== 1'b0 || seg_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset X=%b cnt=%0d act=%b rdy=%b expected 0 0 0 1",
               X, fifo_count, x_active, seg_ready);
    end
    sb.delete();
    act_len = 0;
    @(negedge clock);
    reset = 1'b0;
    #1 mon_en = 1;
    repeat (5) @(negedge clock);
    #1;
    checks++;
    if (X !== 1'b0 || x_active !== 1'b0 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL post_reset X=%b act=%b cnt=%0d expected 0 0 0", X, x_active, fifo_count);
    end
    push_seg(1'b1, 8'd2);
    drain(50);
    checks++;
    if (last_run != 2) begin
      failures++;
      $display("FAIL post_reset_seg run=%0d expected 2", last_run);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reference();
    test_full();
    test_zero_len();
    test_max_len();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fsm_pattern_gen.md
Name: fsm_pattern_gen

Overview:
- Synthesizable driver for the serial X input of the sequence-detecting FSM blocks. It is the stimulus end of the X/Y1/Y2 interface, built in hardware instead of bench code.
- Accepts run-length segments {level, length} over a valid/ready handshake and buffers them in a small FIFO.
- Replays each segment as a registered level on X for exactly length clock cycles.
- Sits in front of fsm_top in FPGA/self-test builds; a bench or host pushes the waveform as segments.

Parameters:
- LEN_W, 8, width of segment length field; max run is 2^LEN_W-1 cycles.
- DEPTH, 4, segment FIFO depth in entries; power of 2, >=2.
- IDLE_LEVEL, 0, value driven on X when no segment is active.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- seg_valid  input  1  segment offered.
- seg_ready  output  1  FIFO can accept; high when FIFO not full.
- seg_level  input  1  X value for the segment.
- seg_len  input  LEN_W  segment duration in clock cycles.
- X  output  1  registered serial output to the FSM under drive.
- x_active  output  1  high while X carries segment data.
- seg_done  output  1  high during the last cycle of each segment.
- fifo_count  output  $clog2(DEPTH)+1  entries currently buffered.

Behaviour:
- Reset (async, active-high): X=IDLE_LEVEL, x_active=0, seg_done=0, fifo_count=0, FIFO pointers=0, state=IDLE, run counter=0.
- Handshake:
  - Transfer occurs on a rising edge with seg_valid && seg_ready.
  - seg_ready = (fifo_count != DEPTH). It is combinational from registered count and has no dependence on seg_valid.
  - There is no pass-through when full: a pop in the same cycle does not raise seg_ready.
- Zero length: seg_len==0 is accepted (handshake completes) and discarded. Nothing is written, and no seg_done is produced.
- FIFO: circular buffer, wrap-around pointers. fifo_count is updated every edge:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- State machine (IDLE, RUN):
  - IDLE: if FIFO non-empty, pop head. Then X<=level, cnt<=len-1, x_active<=1, go RUN. Otherwise X holds IDLE_LEVEL.
  - RUN, cnt!=0: cnt<=cnt-1; X holds.
  - RUN, cnt==0, FIFO non-empty: pop next segment in the same edge. X<=new level, cnt<=len-1. There is no gap cycle between segments.
  - RUN, cnt==0, FIFO empty: X<=IDLE_LEVEL, x_active<=0, go IDLE.
- seg_done = (state==RUN && cnt==0). It is a one-cycle pulse per segment; for len=1 it is high for that single cycle.
- Latency:
  - A segment pushed into an empty FIFO with state IDLE at edge N is popped at edge N+1.
  - X shows the segment level from edge N+1 through edge N+1+len.
  - Push-then-pop is 1 cycle; no same-edge bypass.
- Push during IDLE with empty FIFO and a simultaneous pop attempt: the pop sees the pre-edge empty FIFO, so there is no pop until the next edge.
- Consecutive segments of equal level produce a continuous level on X. Boundaries are visible only via seg_done.
- Reset asserted mid-segment:
  - X returns to IDLE_LEVEL immediately (asynchronous).
  - The FIFO is flushed.
  - After deassertion, the block waits for new segments.

Test Plan:
- Reference waveform: push {0,3},{1,4},{0,7},{1,10},{0,4} back-to-back (LEN_W=8, DEPTH=4) -> X = 0x3,1x4,0x7,1x10,0x4 with no gaps. seg_ready deasserts when 4 entries are buffered. seg_done pulses at cycles 3,7,14,24,28 after first pop. X then returns to 0 and x_active=0.
- Single segment {1,1} into idle block -> X=1 for exactly one cycle starting one edge after the push. seg_done is high in that same cycle; fifo_count goes 0->1->0.
- Full FIFO: hold seg_valid with 6 segments of len 5 while the generator runs -> seg_ready is low whenever fifo_count==4. No segment is lost or duplicated, and the output order matches input order.
- Zero-length: push {1,0} between {0,2} and {0,2} -> X stays 0 for 4 cycles. Exactly 2 seg_done pulses occur; the handshake for {1,0} completes.
- Max length: push {1,255} -> X=1 for exactly 255 cycles, with seg_done only on cycle 255.
- Reset mid-run: assert reset 3 cycles into {1,10} with 2 entries queued -> X=0, fifo_count=0, x_active=0 immediately. After release, X stays 0 until a new segment is pushed.
